// File: rtl/sa_result_drain_pkg.sv
// Shared definitions for the systolic-array result drain: FSM encoding,
// array dimension, data widths and the buffer addressing helper.
package sa_result_drain_pkg;

  localparam int N     = 4;   // array is N x N
  localparam int OUT_W = 8;   // drained element width
  localparam int IN_W  = 24;  // raw column output width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Row-major buffer address of element (r, j): 4*r + j.
  function automatic logic [3:0] buf_addr(input logic [1:0] r, input logic [1:0] j);
    return {r, j};
  endfunction

endpackage

// File: rtl/sa_sat8.sv
// 24-to-8 bit conversion of one array column: unsigned saturation when SAT
// is set, plain truncation otherwise. o_over flags a clipped value.
module sa_sat8
  import sa_result_drain_pkg::*;
#(
  parameter int SAT = 1
) (
  input  logic [IN_W-1:0]  i_val,
  output logic [OUT_W-1:0] o_data,
  output logic             o_over
);

  logic w_high;

  assign w_high = |i_val[IN_W-1:OUT_W];

  // Pick the saturated or truncated form of the column value.
  always_comb begin
    o_data = i_val[OUT_W-1:0];
    o_over = 1'b0;
    if ((SAT != 0) && w_high) begin
      o_data = {OUT_W{1'b1}};
      o_over = 1'b1;
    end else begin
      o_data = i_val[OUT_W-1:0];
      o_over = 1'b0;
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Captures the skewed 4x4 result wavefront leaving a systolic array into a
// 16 x 8 bit buffer, then drains it row-major over a valid/ready port.
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int BASE_LAT = 4,
  parameter int SAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  c1_in,
  input  logic [IN_W-1:0]  c2_in,
  input  logic [IN_W-1:0]  c3_in,
  input  logic [IN_W-1:0]  c4_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_idx,
  output logic             busy,
  output logic             done,
  output logic             sat_flag
);

  // The counter is compared against its incremented value so that the
  // first capture cycle lands exactly BASE_LAT cycles after start.
  localparam logic [7:0] WAIT_END = 8'(BASE_LAT - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_wcnt;
  logic [7:0]       w_wcnt_inc;
  logic [2:0]       r_k;
  logic [OUT_W-1:0] r_buf [N*N];
  logic [OUT_W-1:0] r_out_data;
  logic [3:0]       r_out_idx;
  logic             r_out_valid, r_done, r_busy, r_sat_flag;

  logic [IN_W-1:0]  w_col  [N];
  logic [OUT_W-1:0] w_conv [N];
  logic [N-1:0]     w_over;
  logic [N-1:0]     w_act;
  logic [1:0]       w_row  [N];
  logic             w_xfer, w_last;

  assign w_col[0]   = c1_in;
  assign w_col[1]   = c2_in;
  assign w_col[2]   = c3_in;
  assign w_col[3]   = c4_in;
  assign w_wcnt_inc = r_wcnt + 8'd1;
  assign w_xfer     = r_out_valid && out_ready;
  assign w_last     = w_xfer && (r_out_idx == 4'd15);

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_col
      sa_sat8 #(.SAT(SAT)) u_sat (
        .i_val  (w_col[g]),
        .o_data (w_conv[g]),
        .o_over (w_over[g])
      );
    end
  endgenerate

  // Column j carries row k-j during capture cycle k when 0 <= k-j <= 3.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_act[j] = 1'b0;
      w_row[j] = 2'd0;
      if ((r_k >= 3'(j)) && ((r_k - 3'(j)) <= 3'd3)) begin
        w_act[j] = 1'b1;
        w_row[j] = 2'(r_k - 3'(j));
      end else begin
        w_act[j] = 1'b0;
        w_row[j] = 2'd0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; starts outside IDLE are ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (BASE_LAT <= 1) ? ST_CAPTURE : ST_WAIT;
        else       w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (w_wcnt_inc == WAIT_END) w_state_nxt = ST_CAPTURE;
        else                        w_state_nxt = ST_WAIT;
      end
      ST_CAPTURE: begin
        if (r_k == 3'd6) w_state_nxt = ST_DRAIN;
        else             w_state_nxt = ST_CAPTURE;
      end
      ST_DRAIN: begin
        if (w_last) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters, sticky saturation flag and the registered drain outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt      <= 8'd0;
      r_k         <= 3'd0;
      r_out_data  <= '0;
      r_out_idx   <= 4'd0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_done <= w_last;
      r_busy <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_wcnt <= 8'd0;
          r_k    <= 3'd0;
          if (start) r_sat_flag <= 1'b0;
        end
        ST_WAIT: begin
          r_wcnt <= w_wcnt_inc;
          r_k    <= 3'd0;
        end
        ST_CAPTURE: begin
          r_k        <= r_k + 3'd1;
          r_sat_flag <= r_sat_flag | (|(w_over & w_act));
        end
        ST_DRAIN: begin
          if (!r_out_valid) begin
            // first DRAIN cycle: present element 0
            r_out_valid <= 1'b1;
            r_out_idx   <= 4'd0;
            r_out_data  <= r_buf[0];
          end else if (w_last) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= 4'd0;
            r_out_data  <= '0;
          end else if (w_xfer) begin
            r_out_idx  <= r_out_idx + 4'd1;
            r_out_data <= r_buf[r_out_idx + 4'd1];
          end
        end
        default: begin
          r_wcnt <= 8'd0;
          r_k    <= 3'd0;
        end
      endcase
    end
  end

  // Store converted column values along the skew diagonal; no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == ST_CAPTURE) begin
      for (int j = 0; j < N; j++) begin
        if (w_act[j]) r_buf[buf_addr(w_row[j], 2'(j))] <= w_conv[j];
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: a saturating and a truncating instance share
// stimulus and are compared cycle by cycle against a frame-level model.
module tb_sa_result_drain;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [23:0] c1_in, c2_in, c3_in, c4_in;
  logic [7:0]  o1_data, o0_data;
  logic [3:0]  o1_idx, o0_idx;
  logic        o1_valid, o1_busy, o1_done, o1_sat;
  logic        o0_valid, o0_busy, o0_done, o0_sat;

  always #5 clk = ~clk;

  sa_result_drain #(.BASE_LAT(BL), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .c1_in(c1_in), .c2_in(c2_in), .c3_in(c3_in), .c4_in(c4_in),
    .out_data(o1_data), .out_valid(o1_valid), .out_ready(out_ready),
    .out_idx(o1_idx), .busy(o1_busy), .done(o1_done), .sat_flag(o1_sat));

  sa_result_drain #(.BASE_LAT(BL), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .c1_in(c1_in), .c2_in(c2_in), .c3_in(c3_in), .c4_in(c4_in),
    .out_data(o0_data), .out_valid(o0_valid), .out_ready(out_ready),
    .out_idx(o0_idx), .busy(o0_busy), .done(o0_done), .sat_flag(o0_sat));

  typedef struct {
    int          idx;
    logic [23:0] v;
    logic [7:0]  e1;
    logic [7:0]  e0;
    logic        es;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] m [16];
  logic [7:0]  got1 [16];
  logic [7:0]  got0 [16];
  logic        got_sat1, got_sat0;
  int          done_cyc;
  vec_t        tbl [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_sat(input logic [23:0] v);
    return (v > 24'd255) ? 8'd255 : v[7:0];
  endfunction

  task automatic load_base();
    for (int i = 0; i < 16; i++) m[i] = 24'(16 * (i / 4) + (i % 4));
  endtask

  // element (r,j) appears on column j at cycle BL+r+j; anything else is noise
  task automatic drive_c(input int n);
    logic [23:0] v [4];
    for (int j = 0; j < 4; j++) begin
      int r;
      r = n - BL - j;
      if (r >= 0 && r <= 3) v[j] = m[4 * r + j];
      else                  v[j] = 24'($urandom);
    end
    c1_in = v[0]; c2_in = v[1]; c3_in = v[2]; c4_in = v[3];
  endtask

  // ready_mode: 0 always ready, 1 random, 2 three-cycle stall at element 5.
  // start_x / rst_x: pulse start / rst while element start_x / rst_x is offered.
  task automatic run_frame(input int ready_mode, input int start_x, input int rst_x);
    int   xf, stall_left, done_at;
    bit   stalled, xstart_done, exp_valid, exp_busy, exp_done, rdy;
    logic sat_any;
    xf = 0; stall_left = 0; stalled = 0; xstart_done = 0; done_at = -1; done_cyc = -1;
    sat_any = 1'b0;
    for (int i = 0; i < 16; i++) if (m[i] > 24'd255) sat_any = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      exp_valid = (n >= BL + 8) && (xf < 16);
      exp_busy  = (n >= 1) && (xf < 16);
      exp_done  = (n == done_at);
      start = (n == 0);
      if (exp_valid && xf == start_x && !xstart_done) begin
        start = 1'b1; xstart_done = 1'b1;
      end
      if (ready_mode == 1) rdy = ($urandom_range(0, 2) != 0);
      else if (ready_mode == 2) begin
        if (exp_valid && xf == 5 && !stalled) begin stalled = 1'b1; stall_left = 3; end
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else rdy = 1'b1;
      end else rdy = 1'b1;
      out_ready = rdy;
      drive_c(n);
      if (exp_valid && xf == rst_x) begin
        rst = 1'b1; #1;
        chk("rst_async_sat1", {o1_data, o1_idx, o1_valid, o1_done, o1_busy, o1_sat}, 32'd0);
        chk("rst_async_sat0", {o0_data, o0_idx, o0_valid, o0_done, o0_busy, o0_sat}, 32'd0);
        #1; rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        return;
      end
      @(negedge clk);
      chk("ctl_sat1", {o1_valid, o1_busy, o1_done}, {exp_valid, exp_busy, exp_done});
      chk("ctl_sat0", {o0_valid, o0_busy, o0_done}, {exp_valid, exp_busy, exp_done});
      if (exp_valid) begin
        chk("idx_sat1", o1_idx, 32'(xf));
        chk("idx_sat0", o0_idx, 32'(xf));
        chk("data_sat1", o1_data, exp_sat(m[xf]));
        chk("data_sat0", o0_data, m[xf][7:0]);
      end
      if (n == 1) begin
        chk("sat_clear_sat1", o1_sat, 32'd0);
        chk("sat_clear_sat0", o0_sat, 32'd0);
      end
      if (exp_done) begin
        got_sat1 = o1_sat; got_sat0 = o0_sat;
        chk("sat_flag_sat1", o1_sat, sat_any);
        chk("sat_flag_sat0", o0_sat, 32'd0);
      end
      if (o1_done) done_cyc = n;
      if (exp_valid && rdy) begin
        got1[xf] = o1_data; got0[xf] = o0_data;
        xf++;
        if (xf == 16) done_at = n + 1;
      end
      if (done_at >= 0 && n == done_at + 2) begin
        start = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL frame_timeout transfers=%0d required=16", xf);
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{idx: 6,  v: 24'd300,      e1: 8'd255, e0: 8'd44,   es: 1'b1};
    tbl[1] = '{idx: 0,  v: 24'd256,      e1: 8'd255, e0: 8'd0,    es: 1'b1};
    tbl[2] = '{idx: 15, v: 24'd255,      e1: 8'd255, e0: 8'd255,  es: 1'b0};
    tbl[3] = '{idx: 12, v: 24'hFFFFFF,   e1: 8'd255, e0: 8'd255,  es: 1'b1};
    tbl[4] = '{idx: 9,  v: 24'h001234,   e1: 8'd255, e0: 8'h34,   es: 1'b1};
    tbl[5] = '{idx: 3,  v: 24'd7,        e1: 8'd7,   e0: 8'd7,    es: 1'b0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    c1_in = 24'd0; c2_in = 24'd0; c3_in = 24'd0; c4_in = 24'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_sat1", {o1_data, o1_idx, o1_valid, o1_done, o1_busy, o1_sat}, 32'd0);
    chk("reset_sat0", {o0_data, o0_idx, o0_valid, o0_done, o0_busy, o0_sat}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // basic injection: 16r+j, always ready, done 28 cycles after start
    load_base();
    run_frame(0, -1, -1);
    for (int i = 0; i < 16; i++) chk("inject_seq", got1[i], 32'(16 * (i / 4) + (i % 4)));
    chk("inject_done_lat", done_cyc, 32'd28);

    // conversion vectors, one out-of-pattern value per frame
    for (int t = 0; t < 6; t++) begin
      load_base();
      m[tbl[t].idx] = tbl[t].v;
      run_frame(0, -1, -1);
      chk("vec_data_sat1", got1[tbl[t].idx], tbl[t].e1);
      chk("vec_data_sat0", got0[tbl[t].idx], tbl[t].e0);
      chk("vec_flag_sat1", got_sat1, tbl[t].es);
      chk("vec_flag_sat0", got_sat0, 32'd0);
    end

    // backpressure: 3 idle-ready cycles at element 5
    load_base();
    run_frame(2, -1, -1);
    chk("stall_done_lat", done_cyc, 32'd31);

    // start during drain at element 8 is ignored
    load_base();
    run_frame(0, 8, -1);
    chk("start_in_drain_lat", done_cyc, 32'd28);

    // start coinciding with the final transfer is ignored
    load_base();
    run_frame(0, 15, -1);
    chk("start_at_last_lat", done_cyc, 32'd28);

    // reset mid-drain, then a clean frame
    load_base();
    run_frame(0, -1, 10);
    @(negedge clk);
    chk("post_rst_idle", {o1_valid, o1_busy, o1_done}, 32'd0);
    run_frame(0, -1, -1);
    chk("post_rst_done_lat", done_cyc, 32'd28);

    // randomized frames with random backpressure
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16; i++)
        m[i] = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 255));
      run_frame(1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 Parameter BASE_LAT, default 4: cycles from start to the first result (row 0, column 0) on c1_in.
REQ-002 Parameter SAT, default 1: 1 = unsigned saturate to 8 bits; 0 = truncate to bits [7:0].
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse, aligned with the first skewed activation beat into the array.
REQ-006 c1_in..c4_in  input  24 each  array column outputs, unsigned.
REQ-007 out_data  output  8  drained result element.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-010 out_idx  output  4  row-major index (4*r + j) of out_data.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the 16th transfer.
REQ-013 sat_flag  output  1  sticky per frame; set if any captured value exceeded 255 while SAT=1.

Function
REQ-014 FSM states: IDLE, WAIT, CAPTURE, DRAIN.
REQ-015 IDLE: start moves the FSM to WAIT, loads the wait counter with 0, and clears sat_flag.
REQ-016 WAIT: counter increments each cycle; when it equals BASE_LAT-1, the FSM moves to CAPTURE with capture counter k=0.
REQ-017 CAPTURE lasts exactly 7 cycles (k=0..6).
REQ-018 At capture cycle k, for each column j in 0..3 with 0 <= k-j <= 3, buf[k-j][j] stores the converted c(j+1)_in.
REQ-019 Result (r,j) is therefore sampled at cycle start+BASE_LAT+r+j, counting the start cycle as cycle 0.
REQ-020 Conversion: SAT=1 gives min(value,255); SAT=0 gives value[7:0].
REQ-021 Conversion is performed at capture, so the buffer is 16 x 8 bits.
REQ-022 After k=6 the FSM moves to DRAIN with index 0, and out_valid rises the following cycle.
REQ-023 DRAIN: out_data=buf[idx/4][idx%4] and out_idx=idx; the index advances only on a transfer.
REQ-024 While out_ready is low, out_data, out_idx, and out_valid hold stable.
REQ-025 On the transfer at idx=15, out_valid drops next cycle, done pulses for one cycle, and the FSM returns to IDLE.
REQ-026 A start asserted in any state other than IDLE is ignored and has no effect on the frame in progress.
REQ-027 start and the last transfer in the same cycle: start is ignored; the FSM takes IDLE for at least one cycle.
REQ-028 The c*_in values are don't-care outside their capture cycles.
REQ-029 Minimum start-to-done latency, with out_ready held high: BASE_LAT + 7 + 17 cycles.

Reset
REQ-030 rst asynchronously forces state IDLE and clears all counters, out_data, out_idx, out_valid, done, busy, and sat_flag to 0.
REQ-031 Buffer contents need not be reset.
REQ-032 Reset mid-frame (any state) abandons the frame; no partial drain resumes after rst deasserts.

Structure
REQ-033 A shared package holds the FSM state encoding, the array dimension constant N=4, and the 8-bit output width constant.
REQ-034 One sub-module, sa_sat8, performs the 24-to-8 conversion selected by SAT; it is instantiated four times, once per column.

Verification
REQ-035 Injection: drive c(j+1)_in = 16*r + j at each cycle start+4+r+j, with out_ready=1.
  - Required: out_data sequence 0,1,2,3,16,17,...,51, with out_idx 0..15.
  - Required: done fires exactly 28 cycles after start.
REQ-036 Saturation, SAT=1: value 300 at (1,2) gives out_data 255 at idx 6 and sat_flag=1.
  - With SAT=0, the same value gives out_data 44 and sat_flag=0.
REQ-037 Backpressure: drop out_ready for 3 cycles while idx=5.
  - Required: out_data and out_idx hold steady.
  - Required: no element is lost or duplicated, and the full 16-element sequence completes.
REQ-038 Start during DRAIN at idx=8: drain continues uninterrupted to idx 15, and busy falls only after done.
REQ-039 rst pulse mid-DRAIN at idx=10: all outputs are 0 immediately.
  - Required: a fresh start afterwards yields a complete, correct 16-element frame.
